// File: rtl/vx_commit_arb_pkg.sv
// Shared types and sizing for the commit arbiter: one commit packet per stream.
package vx_commit_arb_pkg;

  localparam int NUM_REQS     = 4;
  localparam int NUM_THREADS  = 4;
  localparam int NW_BITS      = 2;
  localparam int NR_BITS      = 5;
  localparam int UUID_BITS    = 44;
  localparam int CNT_BITS     = $clog2(NUM_REQS * NUM_THREADS + 1);
  localparam int REQ_IDX_BITS = $clog2(NUM_REQS);

  typedef struct packed {
    logic [UUID_BITS-1:0]      uuid;
    logic [NW_BITS-1:0]        wid;
    logic [NUM_THREADS-1:0]    tmask;
    logic [31:0]               pc;
    logic [NR_BITS-1:0]        rd;
    logic                      wb;
    logic                      eop;
    logic [NUM_THREADS*32-1:0] data;
  } commit_t;

  localparam int COMMIT_W = $bits(commit_t);

  function automatic logic [CNT_BITS-1:0] popcount(input logic [NUM_THREADS-1:0] m);
    logic [CNT_BITS-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      cnt = cnt + CNT_BITS'(m[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/vx_rr_arbiter.sv
// Round-robin arbiter: searches upward from the pointer, pointer moves past the
// winner only when the grant is accepted.
module vx_rr_arbiter
  import vx_commit_arb_pkg::*;
#(
  parameter int N        = NUM_REQS,
  parameter int IDX_BITS = $clog2(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        req,
  input  logic                accept,
  output logic [N-1:0]        grant,
  output logic [IDX_BITS-1:0] grant_idx,
  output logic                grant_valid
);

  logic [IDX_BITS-1:0] ptr;
  int                  k;

  // pick the first requester at ptr, ptr+1, ... wrapping at N
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    k           = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!grant_valid && req[k]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_BITS'(k);
        grant[k]    = 1'b1;
      end
    end
  end

  // advance the pointer past an accepted winner, hold otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_idx == IDX_BITS'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/vx_commit_arb.sv
// Commit arbiter: non-writeback commits retire freely, writeback commits share
// one registered writeback port, and retired thread-instructions are counted
// at input fire for the CSR block.
module vx_commit_arb
  import vx_commit_arb_pkg::*;
(
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQS-1:0]                  in_valid,
  output logic [NUM_REQS-1:0]                  in_ready,
  input  logic [NUM_REQS*UUID_BITS-1:0]        in_uuid,
  input  logic [NUM_REQS*NW_BITS-1:0]          in_wid,
  input  logic [NUM_REQS*NUM_THREADS-1:0]      in_tmask,
  input  logic [NUM_REQS*32-1:0]               in_PC,
  input  logic [NUM_REQS*NR_BITS-1:0]          in_rd,
  input  logic [NUM_REQS-1:0]                  in_wb,
  input  logic [NUM_REQS-1:0]                  in_eop,
  input  logic [NUM_REQS*NUM_THREADS*32-1:0]   in_data,
  output logic                                 wb_valid,
  input  logic                                 wb_ready,
  output logic [UUID_BITS-1:0]                 wb_uuid,
  output logic [NW_BITS-1:0]                   wb_wid,
  output logic [NUM_THREADS-1:0]               wb_tmask,
  output logic [31:0]                          wb_PC,
  output logic [NR_BITS-1:0]                   wb_rd,
  output logic                                 wb_eop,
  output logic [NUM_THREADS*32-1:0]            wb_data,
  output logic                                 cmt_valid,
  output logic [CNT_BITS-1:0]                  cmt_size
);

  commit_t                 stream [NUM_REQS];
  commit_t                 nxt;
  commit_t                 wb_q;
  logic [COMMIT_W-1:0]     wb_q_bits;
  logic [NUM_REQS-1:0]     req;
  logic [NUM_REQS-1:0]     grant;
  logic [NUM_REQS-1:0]     fire;
  logic [REQ_IDX_BITS-1:0] grant_idx;
  logic                    grant_valid;
  logic                    out_en;
  logic [CNT_BITS-1:0]     retire_sum;
  logic [CNT_BITS-1:0]     cmt_size_q;
  logic                    cmt_valid_q;

  // slice the flat input buses into one packet per stream
  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      stream[i].uuid  = in_uuid[i*UUID_BITS +: UUID_BITS];
      stream[i].wid   = in_wid[i*NW_BITS +: NW_BITS];
      stream[i].tmask = in_tmask[i*NUM_THREADS +: NUM_THREADS];
      stream[i].pc    = in_PC[i*32 +: 32];
      stream[i].rd    = in_rd[i*NR_BITS +: NR_BITS];
      stream[i].wb    = in_wb[i];
      stream[i].eop   = in_eop[i];
      stream[i].data  = in_data[i*NUM_THREADS*32 +: NUM_THREADS*32];
    end
  end

  // the wb bit of the output register doubles as wb_valid
  assign wb_q     = commit_t'(wb_q_bits);
  assign wb_valid = wb_q.wb;
  assign out_en   = !wb_valid || wb_ready;
  assign req      = in_valid & in_wb;

  vx_rr_arbiter #(
    .N        (NUM_REQS),
    .IDX_BITS (REQ_IDX_BITS)
  ) u_rr_arbiter (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .accept      (grant_valid && out_en),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // non-writeback streams are always ready; only the winner sees out_en
  always_comb begin
    in_ready = ~in_wb | (grant & {NUM_REQS{out_en}});
    fire     = in_valid & in_ready;
  end

  // thread-instructions retired this cycle, counted on eop fires only
  always_comb begin
    retire_sum = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (fire[i] && in_eop[i]) retire_sum = retire_sum + popcount(stream[i].tmask);
    end
  end

  // winner's packet, with the wb bit carrying whether anything was granted
  always_comb begin
    nxt    = stream[grant_idx];
    nxt.wb = grant_valid;
  end

  // writeback output stage, loads only when the slot is free or draining
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_q_bits <= '0;
    end else if (out_en) begin
      wb_q_bits <= nxt;
    end
  end

  // retirement report, one cycle after the fires it counts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmt_size_q  <= '0;
      cmt_valid_q <= 1'b0;
    end else begin
      cmt_size_q  <= retire_sum;
      cmt_valid_q <= (retire_sum != '0);
    end
  end

  assign cmt_valid = cmt_valid_q;
  assign cmt_size  = cmt_size_q;
  assign wb_uuid   = wb_q.uuid;
  assign wb_wid    = wb_q.wid;
  assign wb_tmask  = wb_q.tmask;
  assign wb_PC     = wb_q.pc;
  assign wb_rd     = wb_q.rd;
  assign wb_eop    = wb_q.eop;
  assign wb_data   = wb_q.data;

endmodule

// File: tb/tb_vx_commit_arb.sv
// Directed scenarios for vx_commit_arb with a queue of expected writebacks.
module tb_vx_commit_arb;

  localparam int NR = 4;
  localparam int NT = 4;
  localparam int PW = 44 + 2 + 4 + 32 + 5 + 1 + 128;
  typedef logic [PW-1:0] pay_t;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   in_valid, in_ready, in_wb, in_eop;
  logic [NR*44-1:0] in_uuid;
  logic [NR*2-1:0] in_wid;
  logic [NR*NT-1:0] in_tmask;
  logic [NR*32-1:0] in_PC;
  logic [NR*5-1:0] in_rd;
  logic [NR*NT*32-1:0] in_data;
  logic            wb_valid, wb_ready, wb_eop, cmt_valid;
  logic [43:0]     wb_uuid;
  logic [1:0]      wb_wid;
  logic [3:0]      wb_tmask;
  logic [31:0]     wb_PC;
  logic [4:0]      wb_rd;
  logic [127:0]    wb_data;
  logic [4:0]      cmt_size;

  logic [NR-1:0] s_valid, s_wb, s_eop;
  logic [3:0]    s_tmask [NR];
  int            s_tag   [NR];
  pay_t          sb [$];
  int            total  = 0;
  int            passed = 0;

  vx_commit_arb dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_uuid(in_uuid), .in_wid(in_wid),
    .in_tmask(in_tmask), .in_PC(in_PC), .in_rd(in_rd), .in_wb(in_wb),
    .in_eop(in_eop), .in_data(in_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_uuid(wb_uuid), .wb_wid(wb_wid),
    .wb_tmask(wb_tmask), .wb_PC(wb_PC), .wb_rd(wb_rd), .wb_eop(wb_eop),
    .wb_data(wb_data), .cmt_valid(cmt_valid), .cmt_size(cmt_size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [43:0] f_uuid(input int i);
    return {36'(s_tag[i]), 8'(i)};
  endfunction

  function automatic logic [31:0] f_pc(input int i);
    return 32'h8000_0000 + 32'(s_tag[i] * 64 + i * 4);
  endfunction

  function automatic logic [127:0] f_data(input int i);
    logic [31:0] u;
    u = f_uuid(i)[31:0];
    return {u ^ 32'hAAAA_0000, u + 32'd3, ~u, u};
  endfunction

  function automatic pay_t mk_pay(input int i);
    return {f_uuid(i), 2'(i), s_tmask[i], f_pc(i), 5'(s_tag[i] + i + 1), s_eop[i], f_data(i)};
  endfunction

  function automatic pay_t wb_now();
    return {wb_uuid, wb_wid, wb_tmask, wb_PC, wb_rd, wb_eop, wb_data};
  endfunction

  function automatic pay_t sb_pop();
    pay_t p;
    p = 'x;
    if (sb.size() > 0) p = sb.pop_front();
    return p;
  endfunction

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      in_valid[i]             = s_valid[i];
      in_wb[i]                = s_wb[i];
      in_eop[i]               = s_eop[i];
      in_tmask[i*NT +: NT]    = s_tmask[i];
      in_uuid[i*44 +: 44]     = f_uuid(i);
      in_wid[i*2 +: 2]        = 2'(i);
      in_PC[i*32 +: 32]       = f_pc(i);
      in_rd[i*5 +: 5]         = 5'(s_tag[i] + i + 1);
      in_data[i*128 +: 128]   = f_data(i);
    end
  endtask

  task automatic clear_streams(input int tag);
    s_valid = '0;
    s_wb    = '1;
    s_eop   = '1;
    for (int i = 0; i < NR; i++) begin
      s_tmask[i] = 4'hF;
      s_tag[i]   = tag;
    end
    apply();
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    pay_t e;
    clear_streams(1);
    s_valid  = '1;
    apply();
    wb_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if ({wb_valid, cmt_valid} !== 2'b00)
        $display("FAIL reset_hold cyc%0d: wb_valid,cmt_valid=%b want 00", c, {wb_valid, cmt_valid});
      else passed++;
    end
    reset = 1'b1;
    sb.push_back(mk_pay(0));
    tick();
    e = sb_pop();
    total++;
    if ({wb_valid, wb_now()} !== {1'b1, e})
      $display("FAIL reset_first_grant: got %h uuid=%h want uuid=%h", wb_valid, wb_uuid, e[PW-1 -: 44]);
    else passed++;
    total++;
    if ({cmt_valid, cmt_size} !== {1'b1, 5'd4})
      $display("FAIL reset_first_cmt: got %b/%0d want 1/4", cmt_valid, cmt_size);
    else passed++;
  endtask

  task automatic do_reset();
    clear_streams(0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_round_robin();
    pay_t e;
    do_reset();
    clear_streams(2);
    s_valid  = '1;
    apply();
    wb_ready = 1'b1;
    for (int k = 0; k < 8; k++) sb.push_back(mk_pay(k % NR));
    for (int k = 0; k < 8; k++) begin
      tick();
      e = sb_pop();
      total++;
      if ({wb_valid, wb_now()} !== {1'b1, e})
        $display("FAIL rr_order cyc%0d: valid=%b uuid=%h want uuid=%h", k, wb_valid, wb_uuid, e[PW-1 -: 44]);
      else passed++;
      total++;
      if ({cmt_valid, cmt_size} !== {1'b1, 5'd4})
        $display("FAIL rr_cmt cyc%0d: got %b/%0d want 1/4", k, cmt_valid, cmt_size);
      else passed++;
    end
    clear_streams(2);
    tick();
    total++;
    if (wb_valid !== 1'b0) $display("FAIL rr_drain: wb_valid=%b want 0", wb_valid);
    else passed++;
  endtask

  task automatic test_parallel_retire();
    pay_t e;
    clear_streams(3);
    s_valid    = 4'b1011;
    s_wb       = 4'b0101;
    s_tmask[1] = 4'b0111;
    s_tmask[3] = 4'b0001;
    apply();
    #1;
    total++;
    if (in_ready !== 4'b1011) $display("FAIL par_ready: got %b want 1011", in_ready);
    else passed++;
    sb.push_back(mk_pay(0));
    tick();
    e = sb_pop();
    total++;
    if ({wb_valid, wb_now()} !== {1'b1, e})
      $display("FAIL par_wb: valid=%b uuid=%h want uuid=%h", wb_valid, wb_uuid, e[PW-1 -: 44]);
    else passed++;
    total++;
    if ({cmt_valid, cmt_size} !== {1'b1, 5'd8})
      $display("FAIL par_cmt: got %b/%0d want 1/8", cmt_valid, cmt_size);
    else passed++;
    clear_streams(3);
    tick();
    total++;
    if ({cmt_valid, cmt_size, wb_valid} !== 7'b0)
      $display("FAIL par_idle: cmt=%b/%0d wb_valid=%b want 0/0/0", cmt_valid, cmt_size, wb_valid);
    else passed++;
  endtask

  task automatic test_backpressure();
    pay_t e, hold;
    clear_streams(4);
    s_valid[1] = 1'b1;
    apply();
    wb_ready = 1'b1;
    hold = mk_pay(1);
    sb.push_back(hold);
    tick();
    e = sb_pop();
    total++;
    if ({wb_valid, wb_now()} !== {1'b1, e})
      $display("FAIL bp_first: valid=%b uuid=%h want uuid=%h", wb_valid, wb_uuid, e[PW-1 -: 44]);
    else passed++;
    s_valid    = 4'b1100;
    s_wb       = 4'b0110;
    s_tmask[3] = 4'b0011;
    wb_ready   = 1'b0;
    apply();
    #1;
    total++;
    if (in_ready !== 4'b1001) $display("FAIL bp_ready: got %b want 1001", in_ready);
    else passed++;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if ({wb_valid, wb_now()} !== {1'b1, hold})
        $display("FAIL bp_stable cyc%0d: valid=%b uuid=%h want uuid=%h", c, wb_valid, wb_uuid, hold[PW-1 -: 44]);
      else passed++;
      total++;
      if (in_ready[2] !== 1'b0) $display("FAIL bp_ready2 cyc%0d: got %b want 0", c, in_ready[2]);
      else passed++;
      total++;
      if ({cmt_valid, cmt_size} !== {1'b1, 5'd2})
        $display("FAIL bp_cmt cyc%0d: got %b/%0d want 1/2", c, cmt_valid, cmt_size);
      else passed++;
    end
    wb_ready   = 1'b1;
    s_valid[3] = 1'b0;
    apply();
    #1;
    total++;
    if (in_ready[2] !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready[2]);
    else passed++;
    sb.push_back(mk_pay(2));
    tick();
    e = sb_pop();
    total++;
    if ({wb_valid, wb_now()} !== {1'b1, e})
      $display("FAIL bp_release_wb: valid=%b uuid=%h want uuid=%h", wb_valid, wb_uuid, e[PW-1 -: 44]);
    else passed++;
    total++;
    if ({cmt_valid, cmt_size} !== {1'b1, 5'd4})
      $display("FAIL bp_release_cmt: got %b/%0d want 1/4", cmt_valid, cmt_size);
    else passed++;
    clear_streams(4);
    tick();
  endtask

  task automatic test_eop_idle();
    pay_t e;
    clear_streams(5);
    s_valid[0] = 1'b1;
    s_eop[0]   = 1'b0;
    apply();
    sb.push_back(mk_pay(0));
    tick();
    e = sb_pop();
    total++;
    if ({wb_valid, wb_now()} !== {1'b1, e})
      $display("FAIL eop_wb: valid=%b uuid=%h eop=%b want uuid=%h eop=0", wb_valid, wb_uuid, wb_eop, e[PW-1 -: 44]);
    else passed++;
    total++;
    if ({cmt_valid, cmt_size} !== 6'b0)
      $display("FAIL eop_cmt: got %b/%0d want 0/0", cmt_valid, cmt_size);
    else passed++;
    clear_streams(5);
    tick();
    total++;
    if ({cmt_valid, cmt_size, wb_valid} !== 7'b0)
      $display("FAIL idle: cmt=%b/%0d wb_valid=%b want 0/0/0", cmt_valid, cmt_size, wb_valid);
    else passed++;
  endtask

  task automatic test_async_reset();
    pay_t e;
    clear_streams(6);
    s_valid[2] = 1'b1;
    apply();
    wb_ready = 1'b1;
    sb.push_back(mk_pay(2));
    tick();
    e = sb_pop();
    total++;
    if ({wb_valid, wb_now()} !== {1'b1, e})
      $display("FAIL ar_wb: valid=%b uuid=%h want uuid=%h", wb_valid, wb_uuid, e[PW-1 -: 44]);
    else passed++;
    wb_ready   = 1'b0;
    s_valid    = 4'b1000;
    s_wb[3]    = 1'b0;
    apply();
    tick();
    total++;
    if ({wb_valid, cmt_valid, cmt_size} !== {1'b1, 1'b1, 5'd4})
      $display("FAIL ar_stall: wb_valid=%b cmt=%b/%0d want 1 1/4", wb_valid, cmt_valid, cmt_size);
    else passed++;
    #1;
    reset = 1'b0;
    #1;
    total++;
    if ({wb_valid, cmt_valid, cmt_size} !== 7'b0)
      $display("FAIL ar_async_clear: wb_valid=%b cmt=%b/%0d want 0 0/0", wb_valid, cmt_valid, cmt_size);
    else passed++;
    #1;
    reset = 1'b1;
    clear_streams(7);
    s_valid  = 4'b1010;
    wb_ready = 1'b1;
    apply();
    sb.push_back(mk_pay(1));
    tick();
    e = sb_pop();
    total++;
    if ({wb_valid, wb_now()} !== {1'b1, e})
      $display("FAIL ar_ptr_zero: valid=%b uuid=%h want uuid=%h", wb_valid, wb_uuid, e[PW-1 -: 44]);
    else passed++;
    clear_streams(7);
    tick();
    total++;
    if ({wb_valid, 32'(sb.size())} !== {1'b0, 32'd0})
      $display("FAIL ar_end: wb_valid=%b pending=%0d want 0/0", wb_valid, sb.size());
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    wb_ready = 1'b0;
    clear_streams(0);
    test_reset();
    test_round_robin();
    test_parallel_retire();
    test_backpressure();
    test_eop_idle();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
